// File: rtl/i2c_pkg.sv
// Shared I2C definitions: field widths and the target FSM state encoding.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_WR_BYTE  = 3'd3,
    ST_WR_ACK   = 3'd4,
    ST_RD_BYTE  = 3'd5,
    ST_RD_ACK   = 3'd6,
    ST_IGNORE   = 3'd7
  } state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer with one history flop each; derives SCL edges and
// START/STOP conditions from the synchronized values only.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_hist_q;
  logic                   sda_hist_q;
  logic                   scl_s;

  // Shift raw bus lines through the sync chain; reset to the idle-high bus
  // level so that leaving reset never looks like an edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
      scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
      sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // SCL must be high in both samples so an SDA change racing an SCL edge
  // is never mistaken for START/STOP.
  assign scl_rise  =  scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s &  scl_hist_q;
  assign start_det =  scl_s & scl_hist_q &  sda_hist_q & ~sda_s;
  assign stop_det  =  scl_s & scl_hist_q & ~sda_hist_q &  sda_s;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: address match, ACKed write bytes out on rx_data/rx_valid,
// read bytes fetched via tx_req/tx_data and shifted out MSB first.
// Never stretches SCL; SDA is open drain (pull low or release).
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h42,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  scl,
  inout  wire                   sda,
  input  logic [I2C_BYTE_W-1:0] tx_data,
  output logic [I2C_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_req,
  output logic                  mode,
  output logic                  busy
);

  logic sda_s, scl_rise, scl_fall, start_raw, stop_det, start_det;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock     (clock),
    .reset     (reset),
    .scl       (scl),
    .sda       (sda),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_raw),
    .stop_det  (stop_det)
  );

  assign start_det = start_raw & en;

  state_e                 state_q;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [I2C_BYTE_W-1:0]  shift_q, shift_d;
  logic                   ack_ph_q;   // ACK states: first falling edge seen
  logic                   sda_oe_q;
  logic [I2C_BYTE_W-1:0]  rx_data_q;
  logic                   rx_valid_q, tx_req_q, mode_q, busy_q;

  // Next shift/count values for a received bit.
  always_comb begin
    shift_d   = {shift_q[I2C_BYTE_W-2:0], sda_s};
    bit_cnt_d = bit_cnt_q + 3'd1;
  end

  // Transaction FSM. Order: reset, disable, STOP, START, then SCL-edge work.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ack_ph_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      mode_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      if (!en) begin
        state_q  <= ST_IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
        ack_ph_q <= 1'b0;
      end else if (stop_det) begin
        state_q  <= ST_IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
        ack_ph_q <= 1'b0;
      end else if (start_det) begin
        state_q   <= ST_ADDR;
        bit_cnt_q <= '0;
        shift_q   <= '0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
        ack_ph_q  <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE, ST_IGNORE: sda_oe_q <= 1'b0;
          ST_ADDR: begin
            if (scl_rise) begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_d;
              if (bit_cnt_q == 3'd7) begin
                if (shift_q[I2C_ADDR_W-1:0] == SLAVE_ADDR) begin
                  mode_q   <= sda_s;
                  busy_q   <= 1'b1;
                  ack_ph_q <= 1'b0;
                  state_q  <= ST_ADDR_ACK;
                end else begin
                  state_q <= ST_IGNORE;
                end
              end
            end
          end
          ST_ADDR_ACK, ST_WR_ACK: begin
            if (scl_fall) begin
              if (!ack_ph_q) begin
                sda_oe_q <= 1'b1;
                ack_ph_q <= 1'b1;
              end else begin
                sda_oe_q  <= 1'b0;
                ack_ph_q  <= 1'b0;
                bit_cnt_q <= '0;
                if (state_q == ST_ADDR_ACK && mode_q) begin
                  tx_req_q <= 1'b1;
                  state_q  <= ST_RD_BYTE;
                end else begin
                  state_q <= ST_WR_BYTE;
                end
              end
            end
          end
          ST_WR_BYTE: begin
            if (scl_rise) begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_d;
              if (bit_cnt_q == 3'd7) begin
                rx_data_q  <= shift_d;
                rx_valid_q <= 1'b1;
                ack_ph_q   <= 1'b0;
                state_q    <= ST_WR_ACK;
              end
            end
          end
          ST_RD_BYTE: begin
            // tx_data is captured while tx_req is high; bit7 goes out then,
            // so the count starts at 1 and wraps to 0 after bit0.
            if (tx_req_q) begin
              sda_oe_q  <= ~tx_data[I2C_BYTE_W-1];
              shift_q   <= {tx_data[I2C_BYTE_W-2:0], 1'b0};
              bit_cnt_q <= 3'd1;
            end else if (scl_fall) begin
              if (bit_cnt_q == 3'd0) begin
                sda_oe_q <= 1'b0;
                ack_ph_q <= 1'b0;
                state_q  <= ST_RD_ACK;
              end else begin
                sda_oe_q  <= ~shift_q[I2C_BYTE_W-1];
                shift_q   <= {shift_q[I2C_BYTE_W-2:0], 1'b0};
                bit_cnt_q <= bit_cnt_d;
              end
            end
          end
          ST_RD_ACK: begin
            if (!ack_ph_q) begin
              if (scl_rise) begin
                if (!sda_s) begin
                  ack_ph_q <= 1'b1;
                end else begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IGNORE;
                end
              end
            end else if (scl_fall) begin
              ack_ph_q  <= 1'b0;
              tx_req_q  <= 1'b1;
              bit_cnt_q <= '0;
              state_q   <= ST_RD_BYTE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign sda      = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign mode     = mode_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a behavioural bus master with pull-up on SDA.
module tb_i2c_slave;
  import i2c_pkg::*;

  localparam int Q = 80;  // quarter SCL period; SCL period = 32 system clocks

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       en    = 1'b1;
  logic       scl   = 1'b1;
  logic       m_sda_low = 1'b0;
  logic [7:0] tx_data = 8'h3C;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, mode, busy;
  wire        sda;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clock = ~clock;

  i2c_slave dut (
    .clock    (clock),
    .reset    (reset),
    .en       (en),
    .scl      (scl),
    .sda      (sda),
    .tx_data  (tx_data),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_req   (tx_req),
    .mode     (mode),
    .busy     (busy)
  );

  int errors = 0;
  int checks = 0;

  // Event counters sampled on the falling clock edge, away from DUT updates.
  int rx_cnt = 0, txr_cnt = 0, tgt_low = 0, busy_cnt = 0;
  always @(negedge clock) begin
    if (rx_valid) rx_cnt++;
    if (tx_req) txr_cnt++;
    if (sda === 1'b0 && !m_sda_low) tgt_low++;
    if (busy) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, output logic r);
    m_sda_low = ~b;
    #(Q); scl = 1'b1;
    #(Q); r = sda;
    #(Q); scl = 1'b0;
    #(Q);
  endtask

  task automatic m_start();
    m_sda_low = 1'b0;
    #(Q); scl = 1'b1;
    #(Q); m_sda_low = 1'b1;
    #(Q); scl = 1'b0;
    #(Q);
  endtask

  task automatic m_stop();
    m_sda_low = 1'b1;
    #(Q); scl = 1'b1;
    #(Q); m_sda_low = 1'b0;
    #(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) send_bit(b[i], r);
    send_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic m_ack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, r);
      d[i] = r;
    end
    send_bit(m_ack, r);
  endtask

  logic       ack;
  logic [7:0] d;
  logic       r;
  int         rx0, txr0, low0, busy0;

  initial begin
    #40; reset = 1'b0; #20;
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", {7'd0, rx_valid}, 8'h00);
    chk("rst_tx_req", {7'd0, tx_req}, 8'h00);
    chk("rst_mode", {7'd0, mode}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_sda", {7'd0, sda}, 8'h01);
    chk("rst_state", {5'd0, dut.state_q}, {5'd0, ST_IDLE});

    // 1: write 0xA5 to 0x42
    rx0 = rx_cnt;
    m_start();
    write_byte(8'h84, ack);
    chk("t1_addr_ack", {7'd0, ack}, 8'h00);
    chk("t1_busy", {7'd0, busy}, 8'h01);
    chk("t1_mode", {7'd0, mode}, 8'h00);
    write_byte(8'hA5, ack);
    chk("t1_data_ack", {7'd0, ack}, 8'h00);
    chk("t1_rx_data", rx_data, 8'hA5);
    chk("t1_rx_pulses", 8'(rx_cnt - rx0), 8'd1);
    m_stop(); #(Q);
    chk("t1_busy_stop", {7'd0, busy}, 8'h00);
    chk("t1_state_stop", {5'd0, dut.state_q}, {5'd0, ST_IDLE});

    // 2: read 0x3C from 0x42, master NACK
    txr0 = txr_cnt;
    tx_data = 8'h3C;
    m_start();
    write_byte(8'h85, ack);
    chk("t2_addr_ack", {7'd0, ack}, 8'h00);
    chk("t2_mode", {7'd0, mode}, 8'h01);
    read_byte(1'b1, d);
    chk("t2_read", d, 8'h3C);
    chk("t2_tx_req", 8'(txr_cnt - txr0), 8'd1);
    chk("t2_busy_nack", {7'd0, busy}, 8'h00);
    chk("t2_state_nack", {5'd0, dut.state_q}, {5'd0, ST_IGNORE});
    m_stop(); #(Q);
    chk("t2_state_stop", {5'd0, dut.state_q}, {5'd0, ST_IDLE});

    // 3: wrong address 0x43
    rx0 = rx_cnt; low0 = tgt_low; busy0 = busy_cnt;
    m_start();
    write_byte(8'h86, ack);
    chk("t3_addr_nack", {7'd0, ack}, 8'h01);
    write_byte(8'h00, ack);
    chk("t3_data_nack", {7'd0, ack}, 8'h01);
    m_stop(); #(Q);
    chk("t3_tgt_low", 8'(tgt_low - low0), 8'd0);
    chk("t3_rx_pulses", 8'(rx_cnt - rx0), 8'd0);
    chk("t3_busy_seen", 8'(busy_cnt - busy0), 8'd0);

    // 4: write 0x11, repeated START, read two bytes
    rx0 = rx_cnt; txr0 = txr_cnt;
    tx_data = 8'h3C;
    m_start();
    write_byte(8'h84, ack);
    write_byte(8'h11, ack);
    chk("t4_wr_ack", {7'd0, ack}, 8'h00);
    chk("t4_rx_data", rx_data, 8'h11);
    m_start();
    write_byte(8'h85, ack);
    chk("t4_raddr_ack", {7'd0, ack}, 8'h00);
    chk("t4_mode", {7'd0, mode}, 8'h01);
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, r);
      d[i] = r;
    end
    tx_data = 8'h96;
    send_bit(1'b0, r);
    chk("t4_read0", d, 8'h3C);
    read_byte(1'b1, d);
    chk("t4_read1", d, 8'h96);
    chk("t4_tx_req", 8'(txr_cnt - txr0), 8'd2);
    chk("t4_rx_pulses", 8'(rx_cnt - rx0), 8'd1);
    m_stop(); #(Q);

    // 5: reset while target drives bit 3 (0) of 0xF7
    tx_data = 8'hF7;
    m_start();
    write_byte(8'h85, ack);
    for (int i = 0; i < 4; i++) send_bit(1'b1, r);
    chk("t5_bit3_low", {7'd0, sda}, 8'h00);
    @(negedge clock); reset = 1'b1;
    #10;
    chk("t5_sda_rel", {7'd0, sda}, 8'h01);
    chk("t5_state", {5'd0, dut.state_q}, {5'd0, ST_IDLE});
    chk("t5_rx_data", rx_data, 8'h00);
    chk("t5_busy", {7'd0, busy}, 8'h00);
    chk("t5_mode", {7'd0, mode}, 8'h00);
    @(negedge clock); reset = 1'b0;
    rx0 = rx_cnt; txr0 = txr_cnt;
    for (int i = 0; i < 5; i++) send_bit(1'b1, r);
    m_stop(); #(Q);
    chk("t5_no_txreq", 8'(txr_cnt - txr0), 8'd0);
    chk("t5_no_rxvalid", 8'(rx_cnt - rx0), 8'd0);

    // 6: disabled target ignores a valid address
    rx0 = rx_cnt; busy0 = busy_cnt;
    en = 1'b0;
    m_start();
    chk("t6_state_start", {5'd0, dut.state_q}, {5'd0, ST_IDLE});
    write_byte(8'h84, ack);
    chk("t6_addr_nack", {7'd0, ack}, 8'h01);
    write_byte(8'h5A, ack);
    chk("t6_state", {5'd0, dut.state_q}, {5'd0, ST_IDLE});
    m_stop(); #(Q);
    chk("t6_rx_pulses", 8'(rx_cnt - rx0), 8'd0);
    chk("t6_busy_seen", 8'(busy_cnt - busy0), 8'd0);
    en = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
